// File: rtl/mc_sequencer_if.sv
// Instruction/data memory request-ready handshake between the sequencer and memories.
interface mc_sequencer_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ready;

    modport master (
        output imem_req,
        output dmem_req,
        output dmem_we,
        input  imem_ready,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  dmem_we,
        output imem_ready,
        output dmem_ready
    );
endinterface

// File: rtl/mc_sequencer.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with trap on illegal,
// ECALL/EBREAK and memory timeout.
module mc_sequencer #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    mc_sequencer_if.master     bus,
    input  logic [6:0]         opcode,
    input  logic [2:0]         funct3,
    input  logic               branch_taken,
    output logic               ir_we,
    output logic               rf_we,
    output logic               pc_we,
    output logic [1:0]         pc_sel,
    output logic [2:0]         state,
    output logic               halted,
    output logic [1:0]         trap_cause,
    output logic [CNT_W-1:0]   instret
);

    localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_ALU    = 3'd0,
        C_JAL    = 3'd1,
        C_JALR   = 3'd2,
        C_LOAD   = 3'd3,
        C_STORE  = 3'd4,
        C_BRANCH = 3'd5,
        C_FENCE  = 3'd6
    } class_t;

    state_t              cur_state;
    state_t              nxt_state;
    class_t              cls_q;
    class_t              cls_d;
    class_t              dec_cls;
    logic [1:0]          dec_cause;
    logic [1:0]          cause_d;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [WAIT_W-1:0]   wait_d;
    logic                wait_expire;

    assign state       = cur_state;
    assign halted      = (cur_state == S_TRAP);
    assign wait_expire = (TIMEOUT != 0) && (wait_cnt == WAIT_W'(TIMEOUT - 1));

    // State register plus the side registers that move with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state  <= S_FETCH;
            cls_q      <= C_ALU;
            wait_cnt   <= '0;
            trap_cause <= 2'd0;
            instret    <= '0;
        end else begin
            cur_state  <= nxt_state;
            cls_q      <= cls_d;
            wait_cnt   <= wait_d;
            trap_cause <= cause_d;
            if (pc_we) begin
                instret <= instret + CNT_W'(1);
            end
        end
    end

    // Instruction classification; nonzero dec_cause means the instruction traps.
    always_comb begin
        dec_cls   = C_ALU;
        dec_cause = 2'd0;
        case (opcode)
            7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: dec_cls = C_ALU;
            7'b0001111: dec_cls = C_FENCE;
            7'b1101111: dec_cls = C_JAL;
            7'b1100111: begin
                if (funct3 == 3'b000) dec_cls = C_JALR;
                else                  dec_cause = 2'd1;
            end
            7'b0000011: begin
                if (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) dec_cls = C_LOAD;
                else dec_cause = 2'd1;
            end
            7'b0100011: begin
                if (funct3 inside {3'b000, 3'b001, 3'b010}) dec_cls = C_STORE;
                else dec_cause = 2'd1;
            end
            7'b1100011: begin
                if (funct3 inside {3'b010, 3'b011}) dec_cause = 2'd1;
                else                                dec_cls = C_BRANCH;
            end
            7'b1110011: dec_cause = 2'd2;
            default:    dec_cause = 2'd1;
        endcase
    end

    // Next-state logic.
    always_comb begin
        nxt_state = cur_state;
        cls_d     = cls_q;
        cause_d   = trap_cause;
        wait_d    = '0;
        case (cur_state)
            S_FETCH: begin
                if (bus.imem_ready) begin
                    nxt_state = S_DECODE;
                end else if (wait_expire) begin
                    nxt_state = S_TRAP;
                    cause_d   = 2'd3;
                end else begin
                    wait_d = wait_cnt + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                if (dec_cause != 2'd0) begin
                    nxt_state = S_TRAP;
                    cause_d   = dec_cause;
                end else begin
                    nxt_state = S_EXEC;
                    cls_d     = dec_cls;
                end
            end
            S_EXEC: begin
                case (cls_q)
                    C_LOAD, C_STORE:  nxt_state = S_MEM;
                    C_BRANCH, C_FENCE: nxt_state = S_FETCH;
                    default:          nxt_state = S_WB;
                endcase
            end
            S_MEM: begin
                if (bus.dmem_ready) begin
                    nxt_state = (cls_q == C_LOAD) ? S_WB : S_FETCH;
                end else if (wait_expire) begin
                    nxt_state = S_TRAP;
                    cause_d   = 2'd3;
                end else begin
                    wait_d = wait_cnt + WAIT_W'(1);
                end
            end
            S_WB:    nxt_state = S_FETCH;
            S_TRAP:  nxt_state = S_TRAP;
            default: nxt_state = S_TRAP;
        endcase
    end

    // Strobes: combinational from state/class/ready, held low during reset and in TRAP.
    always_comb begin
        bus.imem_req = 1'b0;
        bus.dmem_req = 1'b0;
        bus.dmem_we  = 1'b0;
        ir_we        = 1'b0;
        rf_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = 2'b00;
        if (!reset) begin
            case (cur_state)
                S_FETCH: begin
                    bus.imem_req = 1'b1;
                    ir_we        = bus.imem_ready;
                end
                S_EXEC: begin
                    if (cls_q == C_BRANCH) begin
                        pc_we  = 1'b1;
                        pc_sel = branch_taken ? 2'b01 : 2'b00;
                    end else if (cls_q == C_FENCE) begin
                        pc_we = 1'b1;
                    end
                end
                S_MEM: begin
                    bus.dmem_req = 1'b1;
                    bus.dmem_we  = (cls_q == C_STORE);
                    pc_we        = (cls_q == C_STORE) && bus.dmem_ready;
                end
                S_WB: begin
                    rf_we  = 1'b1;
                    pc_we  = 1'b1;
                    pc_sel = (cls_q == C_JAL)  ? 2'b01 :
                             (cls_q == C_JALR) ? 2'b10 : 2'b00;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed bench for mc_sequencer: per-cycle state/strobe tables per instruction class.
module tb_mc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        branch_taken;
    logic        ir_we, rf_we, pc_we, halted;
    logic [1:0]  pc_sel, trap_cause;
    logic [2:0]  state;
    logic [31:0] instret;
    logic        z_ir_we, z_rf_we, z_pc_we, z_halted;
    logic [1:0]  z_pc_sel, z_trap_cause;
    logic [2:0]  z_state;
    logic [31:0] z_instret;

    int vec  = 0;
    int errs = 0;

    always #5 clk = ~clk;

    mc_sequencer_if mif ();
    mc_sequencer_if zif ();

    mc_sequencer #(.TIMEOUT(16), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .bus(mif), .opcode(opcode), .funct3(funct3),
        .branch_taken(branch_taken), .ir_we(ir_we), .rf_we(rf_we), .pc_we(pc_we),
        .pc_sel(pc_sel), .state(state), .halted(halted), .trap_cause(trap_cause),
        .instret(instret)
    );

    mc_sequencer #(.TIMEOUT(0), .CNT_W(32)) dut_nt (
        .clk(clk), .reset(reset), .bus(zif), .opcode(opcode), .funct3(funct3),
        .branch_taken(branch_taken), .ir_we(z_ir_we), .rf_we(z_rf_we), .pc_we(z_pc_we),
        .pc_sel(z_pc_sel), .state(z_state), .halted(z_halted), .trap_cause(z_trap_cause),
        .instret(z_instret)
    );

    // {imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel}
    function automatic logic [7:0] strb();
        return {mif.imem_req, ir_we, mif.dmem_req, mif.dmem_we, rf_we, pc_we, pc_sel};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mif.imem_ready = 1'b0;
        mif.dmem_ready = 1'b0;
        branch_taken = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mif.imem_ready = 1'b1;
        mif.dmem_ready = 1'b1;
        #2;
        vec++; if (strb() !== 8'h00) begin errs++; $display("FAIL reset_strobes_pre got %h exp 00", strb()); end
        tick();
        vec++; if (state !== 3'd0) begin errs++; $display("FAIL reset_state got %0d exp 0", state); end
        vec++; if (halted !== 1'b0) begin errs++; $display("FAIL reset_halted got %b exp 0", halted); end
        vec++; if (trap_cause !== 2'd0) begin errs++; $display("FAIL reset_cause got %0d exp 0", trap_cause); end
        vec++; if (instret !== 32'd0) begin errs++; $display("FAIL reset_instret got %0d exp 0", instret); end
        vec++; if (strb() !== 8'h00) begin errs++; $display("FAIL reset_strobes got %h exp 00", strb()); end
        reset = 1'b0;
        #1;
        vec++; if (strb() !== 8'hC0) begin errs++; $display("FAIL reset_release_fetch got %h exp c0", strb()); end
    endtask

    task automatic test_alu();
        logic [2:0] es [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
        logic [7:0] ss [5] = '{8'hC0, 8'h00, 8'h00, 8'h0C, 8'hC0};
        do_reset();
        opcode = 7'b0110011; funct3 = 3'b000; mif.imem_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            vec++; if (state !== es[c]) begin errs++; $display("FAIL alu_state c%0d got %0d exp %0d", c, state, es[c]); end
            vec++; if (strb() !== ss[c]) begin errs++; $display("FAIL alu_strobes c%0d got %h exp %h", c, strb(), ss[c]); end
            tick();
        end
        vec++; if (instret !== 32'd1) begin errs++; $display("FAIL alu_instret got %0d exp 1", instret); end
    endtask

    task automatic test_load();
        logic [2:0] es [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4, 3'd0};
        logic [7:0] ss [8] = '{8'hC0, 8'h00, 8'h00, 8'h20, 8'h20, 8'h20, 8'h0C, 8'h80};
        logic       ir [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic       dr [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        do_reset();
        opcode = 7'b0000011; funct3 = 3'b010;
        for (int c = 0; c < 8; c++) begin
            mif.imem_ready = ir[c]; mif.dmem_ready = dr[c];
            #1;
            vec++; if (state !== es[c]) begin errs++; $display("FAIL load_state c%0d got %0d exp %0d", c, state, es[c]); end
            vec++; if (strb() !== ss[c]) begin errs++; $display("FAIL load_strobes c%0d got %h exp %h", c, strb(), ss[c]); end
            tick();
        end
        vec++; if (instret !== 32'd1) begin errs++; $display("FAIL load_instret got %0d exp 1", instret); end
    endtask

    task automatic test_store();
        logic [2:0] es [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd0};
        logic [7:0] ss [6] = '{8'hC0, 8'h00, 8'h00, 8'h30, 8'h34, 8'h80};
        logic       ir [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic       dr [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        opcode = 7'b0100011; funct3 = 3'b010;
        for (int c = 0; c < 6; c++) begin
            mif.imem_ready = ir[c]; mif.dmem_ready = dr[c];
            #1;
            vec++; if (state !== es[c]) begin errs++; $display("FAIL store_state c%0d got %0d exp %0d", c, state, es[c]); end
            vec++; if (strb() !== ss[c]) begin errs++; $display("FAIL store_strobes c%0d got %h exp %h", c, strb(), ss[c]); end
            tick();
        end
        vec++; if (instret !== 32'd1) begin errs++; $display("FAIL store_instret got %0d exp 1", instret); end
    endtask

    task automatic test_branch();
        logic [2:0] es [7] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd0};
        logic [7:0] ss [7] = '{8'hC0, 8'h00, 8'h05, 8'hC0, 8'h00, 8'h04, 8'h80};
        logic       ir [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       bt [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [2:0] fs [4] = '{3'd0, 3'd1, 3'd2, 3'd0};
        logic [7:0] fq [4] = '{8'hC0, 8'h00, 8'h04, 8'h80};
        do_reset();
        opcode = 7'b1100011; funct3 = 3'b000;
        for (int c = 0; c < 7; c++) begin
            mif.imem_ready = ir[c]; branch_taken = bt[c];
            #1;
            vec++; if (state !== es[c]) begin errs++; $display("FAIL branch_state c%0d got %0d exp %0d", c, state, es[c]); end
            vec++; if (strb() !== ss[c]) begin errs++; $display("FAIL branch_strobes c%0d got %h exp %h", c, strb(), ss[c]); end
            tick();
        end
        vec++; if (instret !== 32'd2) begin errs++; $display("FAIL branch_instret got %0d exp 2", instret); end
        opcode = 7'b0001111; branch_taken = 1'b1;
        for (int c = 0; c < 4; c++) begin
            mif.imem_ready = (c == 0);
            #1;
            vec++; if (state !== fs[c]) begin errs++; $display("FAIL fence_state c%0d got %0d exp %0d", c, state, fs[c]); end
            vec++; if (strb() !== fq[c]) begin errs++; $display("FAIL fence_strobes c%0d got %h exp %h", c, strb(), fq[c]); end
            tick();
        end
        vec++; if (instret !== 32'd3) begin errs++; $display("FAIL fence_instret got %0d exp 3", instret); end
    endtask

    task automatic test_jump();
        logic [6:0] ops [2] = '{7'b1101111, 7'b1100111};
        logic [7:0] wbs [2] = '{8'h0D, 8'h0E};
        logic [2:0] es  [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
        logic [7:0] ss;
        do_reset();
        funct3 = 3'b000;
        for (int k = 0; k < 2; k++) begin
            opcode = ops[k];
            for (int c = 0; c < 5; c++) begin
                mif.imem_ready = (c == 0);
                ss = (c == 0) ? 8'hC0 : (c == 3) ? wbs[k] : (c == 4) ? 8'h80 : 8'h00;
                #1;
                vec++; if (state !== es[c]) begin errs++; $display("FAIL jump%0d_state c%0d got %0d exp %0d", k, c, state, es[c]); end
                vec++; if (strb() !== ss) begin errs++; $display("FAIL jump%0d_strobes c%0d got %h exp %h", k, c, strb(), ss); end
                tick();
            end
        end
        vec++; if (instret !== 32'd2) begin errs++; $display("FAIL jump_instret got %0d exp 2", instret); end
    endtask

    task automatic test_illegal();
        logic [6:0] ops [7] = '{7'b0000000, 7'b1110011, 7'b1110011, 7'b1100011, 7'b1100111, 7'b0000011, 7'b0100011};
        logic [2:0] f3s [7] = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b001, 3'b011, 3'b100};
        logic [1:0] cs  [7] = '{2'd1, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1};
        for (int k = 0; k < 7; k++) begin
            do_reset();
            opcode = ops[k]; funct3 = f3s[k]; mif.imem_ready = 1'b1;
            tick();
            tick();
            mif.dmem_ready = 1'b1; branch_taken = 1'b1;
            vec++; if (state !== 3'd5) begin errs++; $display("FAIL illegal%0d_state got %0d exp 5", k, state); end
            vec++; if (trap_cause !== cs[k]) begin errs++; $display("FAIL illegal%0d_cause got %0d exp %0d", k, trap_cause, cs[k]); end
            for (int c = 0; c < 20; c++) begin
                #1;
                vec++;
                if (halted !== 1'b1 || strb() !== 8'h00 || trap_cause !== cs[k]) begin
                    errs++;
                    $display("FAIL illegal%0d_hold c%0d got halted=%b strobes=%h cause=%0d exp 1/00/%0d",
                             k, c, halted, strb(), trap_cause, cs[k]);
                end
                tick();
            end
            do_reset();
            #1;
            vec++; if (state !== 3'd0 || halted !== 1'b0 || trap_cause !== 2'd0) begin
                errs++; $display("FAIL illegal%0d_recover got state=%0d halted=%b cause=%0d exp 0/0/0", k, state, halted, trap_cause);
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        opcode = 7'b0110011; funct3 = 3'b000;
        for (int c = 0; c < 16; c++) begin
            #1;
            vec++; if (state !== 3'd0 || strb() !== 8'h80) begin
                errs++; $display("FAIL ifetch_wait c%0d got state=%0d strobes=%h exp 0/80", c, state, strb());
            end
            tick();
        end
        #1;
        vec++; if (state !== 3'd5) begin errs++; $display("FAIL ifetch_timeout_state got %0d exp 5", state); end
        vec++; if (trap_cause !== 2'd3) begin errs++; $display("FAIL ifetch_timeout_cause got %0d exp 3", trap_cause); end
        vec++; if (halted !== 1'b1 || strb() !== 8'h00) begin
            errs++; $display("FAIL ifetch_timeout_halt got halted=%b strobes=%h exp 1/00", halted, strb());
        end
        for (int c = 0; c < 30; c++) tick();
        vec++; if (z_state !== 3'd0 || zif.imem_req !== 1'b1 || z_halted !== 1'b0) begin
            errs++; $display("FAIL notimeout_fetch got state=%0d imem_req=%b halted=%b exp 0/1/0", z_state, zif.imem_req, z_halted);
        end
        // Data-side timeout: LOAD waits 16 MEM cycles then traps.
        do_reset();
        opcode = 7'b0000011; funct3 = 3'b000;
        for (int c = 0; c < 19; c++) begin
            mif.imem_ready = (c == 0);
            #1;
            vec++; if (state !== ((c < 3) ? 3'(c) : 3'd3)) begin
                errs++; $display("FAIL dmem_wait_state c%0d got %0d exp %0d", c, state, (c < 3) ? c : 3);
            end
            tick();
        end
        #1;
        vec++; if (state !== 3'd5 || trap_cause !== 2'd3) begin
            errs++; $display("FAIL dmem_timeout got state=%0d cause=%0d exp 5/3", state, trap_cause);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        opcode = 7'b0110011; funct3 = 3'b000; mif.imem_ready = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        vec++; if (instret !== 32'd1) begin errs++; $display("FAIL midrst_pre_instret got %0d exp 1", instret); end
        opcode = 7'b0100011; funct3 = 3'b001;
        tick();
        mif.imem_ready = 1'b0;
        tick();
        tick();
        mif.dmem_ready = 1'b1;
        reset = 1'b1;
        #1;
        vec++; if (state !== 3'd3) begin errs++; $display("FAIL midrst_in_mem got %0d exp 3", state); end
        vec++; if (strb() !== 8'h00) begin errs++; $display("FAIL midrst_strobes got %h exp 00", strb()); end
        tick();
        reset = 1'b0;
        mif.dmem_ready = 1'b0;
        #1;
        vec++; if (state !== 3'd0) begin errs++; $display("FAIL midrst_state got %0d exp 0", state); end
        vec++; if (instret !== 32'd0) begin errs++; $display("FAIL midrst_instret got %0d exp 0", instret); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] es [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0, 3'd1, 3'd2, 3'd3};
        logic [7:0] ss [8] = '{8'hC0, 8'h00, 8'h00, 8'h0C, 8'hC0, 8'h00, 8'h00, 8'h34};
        do_reset();
        mif.dmem_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            opcode = (c < 4) ? 7'b0010011 : 7'b0100011;
            funct3 = 3'b000;
            mif.imem_ready = 1'b1;
            #1;
            vec++; if (state !== es[c]) begin errs++; $display("FAIL b2b_state c%0d got %0d exp %0d", c, state, es[c]); end
            vec++; if (strb() !== ss[c]) begin errs++; $display("FAIL b2b_strobes c%0d got %h exp %h", c, strb(), ss[c]); end
            tick();
        end
        vec++; if (instret !== 32'd2 || state !== 3'd0) begin
            errs++; $display("FAIL b2b_end got instret=%0d state=%0d exp 2/0", instret, state);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        opcode = 7'b0;
        funct3 = 3'b0;
        branch_taken = 1'b0;
        zif.imem_ready = 1'b0;
        zif.dmem_ready = 1'b0;
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_branch();
        test_jump();
        test_illegal();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
